// File: rtl/sro_readout_array.sv
// 4x4 pixel readout core: every pixel writes its TDC word into a private ring
// buffer each bunch crossing. On a level-1 accept the sequencer stops writing,
// reads the triggered slot from each enabled pixel and emits one framed
// packet (header, data words, trailer) on the 30-bit parallel output.
//
// Output handshake: dout_valid is a pure qualifier with no back-pressure.
// While high, dout carries one packet word per clock; while low, dout is zero.
module sro_readout_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 30,
  parameter int L1_DELAY  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     l1acc,
  input  logic                     bc0,
  input  logic [15:0]              roi,
  input  logic [16*DATA_BITS-1:0]  din,
  output logic [DATA_BITS-1:0]     dout,
  output logic                     dout_valid,
  output logic [1:0]               dbg_state
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // S_HDR:  next edge registers the header (RAM read of the trigger slot
  //         is launched on the same edge).
  // S_DATA: one data word per edge, lowest remaining enabled pixel first.
  // S_TRL:  next edge registers the trailer and returns to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_TRL  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_BITS-1:0]  r_waddr, w_waddr_nxt;
  logic [ADDR_BITS-1:0]  r_trig, w_trig_nxt;
  logic [15:0]           r_roi, w_roi_nxt;
  logic [15:0]           r_rem, w_rem_nxt;
  logic [4:0]            r_cnt, w_cnt_nxt;
  logic [DATA_BITS-1:0]  r_dout, w_dout_nxt;
  logic                  r_valid, w_valid_nxt;

  logic                  w_we;
  logic [ADDR_BITS-1:0]  w_addr;
  logic [16*DATA_BITS-1:0] w_rdata;
  logic [3:0]            w_pick;
  logic [15:0]           w_rem_clr;

  // Writing only happens in IDLE; during a readout the shared address holds
  // the trigger slot so every pixel's read register keeps that word.
  assign w_we   = (r_state == S_IDLE);
  assign w_addr = w_we ? r_waddr : r_trig;

  for (genvar p = 0; p < 16; p++) begin : g_pix
    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [DATA_BITS-1:0] r_rd;

    // Single-port buffer with registered read; contents are never reset.
    always_ff @(posedge clock) begin
      if (w_we) begin
        r_mem[w_addr] <= din[p*DATA_BITS +: DATA_BITS];
      end
      r_rd <= r_mem[w_addr];
    end

    assign w_rdata[p*DATA_BITS +: DATA_BITS] = r_rd;
  end

  // Lowest set bit of the remaining-pixel mask selects the next data word.
  always_comb begin
    w_pick = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_rem[i]) begin
        w_pick = 4'(i);
      end
    end
  end

  assign w_rem_clr = r_rem & (r_rem - 16'd1);

  // Sequencer state and registered packet output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_trig  <= '0;
      r_roi   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_waddr <= w_waddr_nxt;
      r_trig  <= w_trig_nxt;
      r_roi   <= w_roi_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state and next-output logic; l1acc and bc0 matter only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_waddr_nxt = r_waddr;
    w_trig_nxt  = r_trig;
    w_roi_nxt   = r_roi;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = '0;
    w_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_waddr_nxt = bc0 ? '0 : r_waddr + ADDR_BITS'(1);
        if (l1acc) begin
          w_trig_nxt  = r_waddr - ADDR_BITS'(L1_DELAY);
          w_roi_nxt   = roi;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        w_dout_nxt  = DATA_BITS'({6'h3C, 8'(r_trig), r_roi});
        w_valid_nxt = 1'b1;
        w_rem_nxt   = r_roi;
        w_cnt_nxt   = 5'd0;
        w_state_nxt = (r_roi == 16'd0) ? S_TRL : S_DATA;
      end
      S_DATA: begin
        w_dout_nxt  = w_rdata[w_pick*DATA_BITS +: DATA_BITS];
        w_valid_nxt = 1'b1;
        w_rem_nxt   = w_rem_clr;
        w_cnt_nxt   = r_cnt + 5'd1;
        if (w_rem_clr == 16'd0) begin
          w_state_nxt = S_TRL;
        end
      end
      S_TRL: begin
        w_dout_nxt  = DATA_BITS'({6'h2A, 19'd0, r_cnt});
        w_valid_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sro_readout_array.sv
// Bench for sro_readout_array: two instances (L1_DELAY 0 and 3) share the
// same stimulus. A queue-based model predicts every output cycle.
module tb_sro_readout_array;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         l1acc = 1'b0;
  logic         bc0   = 1'b0;
  logic [15:0]  roi   = 16'd0;
  logic [479:0] din   = '0;
  logic [29:0]  dout0, dout3;
  logic         dout_valid0, dout_valid3;
  logic [1:0]   dbg_state0, dbg_state3;

  always #5 clock = ~clock;

  sro_readout_array #(.ADDR_BITS(8), .DATA_BITS(30), .L1_DELAY(0)) dut0 (
    .clock(clock), .reset(reset), .l1acc(l1acc), .bc0(bc0), .roi(roi), .din(din),
    .dout(dout0), .dout_valid(dout_valid0), .dbg_state(dbg_state0)
  );

  sro_readout_array #(.ADDR_BITS(8), .DATA_BITS(30), .L1_DELAY(3)) dut3 (
    .clock(clock), .reset(reset), .l1acc(l1acc), .bc0(bc0), .roi(roi), .din(din),
    .dout(dout3), .dout_valid(dout_valid3), .dbg_state(dbg_state3)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: buffer contents, write pointer, pending output words.
  logic [29:0] mem [16][256];
  int          w_ptr = 0;
  logic [29:0] exp_q0[$];
  logic [29:0] exp_q3[$];

  function automatic logic [479:0] rand_din();
    logic [479:0] d;
    for (int p = 0; p < 16; p++) d[30*p +: 30] = 30'($urandom);
    return d;
  endfunction

  function automatic logic [479:0] pat_din(input int k);
    logic [479:0] d;
    for (int p = 0; p < 16; p++) d[30*p +: 30] = 30'((p << 8) | k);
    return d;
  endfunction

  task automatic model_clear();
    exp_q0.delete();
    exp_q3.delete();
    w_ptr = 0;
  endtask

  task automatic do_reset();
    l1acc = 1'b0;
    bc0   = 1'b0;
    @(negedge clock) reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    model_clear();
  endtask

  // One bunch crossing: drive inputs, step the model at the edge and return
  // the expected outputs of both instances just after that edge.
  task automatic bx(input logic l1, input logic b0, input logic [15:0] r,
                    input logic [479:0] d,
                    output logic ev0, output logic [29:0] ed0,
                    output logic ev3, output logic [29:0] ed3);
    bit busy;
    int t0, t3, n;
    l1acc = l1; bc0 = b0; roi = r; din = d;
    @(posedge clock);
    busy = (exp_q0.size() != 0);
    if (exp_q0.size() != 0) begin ev0 = 1'b1; ed0 = exp_q0.pop_front(); end
    else begin ev0 = 1'b0; ed0 = '0; end
    if (exp_q3.size() != 0) begin ev3 = 1'b1; ed3 = exp_q3.pop_front(); end
    else begin ev3 = 1'b0; ed3 = '0; end
    if (!busy) begin
      for (int p = 0; p < 16; p++) mem[p][w_ptr] = d[30*p +: 30];
      if (l1) begin
        t0 = w_ptr;
        t3 = (w_ptr + 256 - 3) % 256;
        n  = 0;
        exp_q0.push_back({6'h3C, 8'(t0), r});
        exp_q3.push_back({6'h3C, 8'(t3), r});
        for (int p = 0; p < 16; p++) begin
          if (r[p]) begin
            exp_q0.push_back(mem[p][t0]);
            exp_q3.push_back(mem[p][t3]);
            n++;
          end
        end
        exp_q0.push_back({6'h2A, 19'd0, 5'(n)});
        exp_q3.push_back({6'h2A, 19'd0, 5'(n)});
      end
      w_ptr = b0 ? 0 : (w_ptr + 1) % 256;
    end
    #1;
    l1acc = 1'b0;
    bc0   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (dout0 !== 30'd0) begin n_err++; $display("FAIL reset_dout0 got=%h exp=0", dout0); end
    n_checks++;
    if (dout_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_valid0 got=%b exp=0", dout_valid0); end
    n_checks++;
    if (dout3 !== 30'd0) begin n_err++; $display("FAIL reset_dout3 got=%h exp=0", dout3); end
    n_checks++;
    if (dout_valid3 !== 1'b0) begin n_err++; $display("FAIL reset_valid3 got=%b exp=0", dout_valid3); end
    @(negedge clock) reset = 1'b1;
    model_clear();
  endtask

  // BX k writes p<<8|k; l1acc on the edge writing k=5.
  task automatic test_trigger(input logic [15:0] r);
    logic ev0, ev3;
    logic [29:0] ed0, ed3;
    logic [29:0] got[$];
    int first, last, n, j;
    first = -1; last = -1;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      bx(c == 5, 1'b0, r, (c <= 5) ? pat_din(c) : rand_din(), ev0, ed0, ev3, ed3);
      n_checks++;
      if (dout_valid0 !== ev0 || dout0 !== ed0) begin
        n_err++;
        $display("FAIL trig_stream0 roi=%h cyc=%0d got v=%b d=%h exp v=%b d=%h", r, c, dout_valid0, dout0, ev0, ed0);
      end
      n_checks++;
      if (dout_valid3 !== ev3 || dout3 !== ed3) begin
        n_err++;
        $display("FAIL trig_stream3 roi=%h cyc=%0d got v=%b d=%h exp v=%b d=%h", r, c, dout_valid3, dout3, ev3, ed3);
      end
      if (dout_valid0 === 1'b1) begin
        got.push_back(dout0);
        if (first < 0) first = c;
        last = c;
      end
    end
    n = $countones(r);
    n_checks++;
    if (first != 6 || last != n + 7 || got.size() != n + 2) begin
      n_err++;
      $display("FAIL trig_window roi=%h got first=%0d last=%0d len=%0d exp first=6 last=%0d len=%0d", r, first, last, got.size(), n + 7, n + 2);
    end
    if (got.size() == n + 2) begin
      n_checks++;
      if (got[0] !== {6'h3C, 8'd5, r}) begin
        n_err++; $display("FAIL trig_header roi=%h got=%h exp=%h", r, got[0], {6'h3C, 8'd5, r});
      end
      j = 1;
      for (int p = 0; p < 16; p++) begin
        if (r[p]) begin
          n_checks++;
          if (got[j] !== 30'((p << 8) | 5)) begin
            n_err++; $display("FAIL trig_data roi=%h pix=%0d got=%h exp=%h", r, p, got[j], 30'((p << 8) | 5));
          end
          j++;
        end
      end
      n_checks++;
      if (got[n + 1] !== {6'h2A, 19'd0, 5'(n)}) begin
        n_err++; $display("FAIL trig_trailer roi=%h got=%h exp=%h", r, got[n + 1], {6'h2A, 19'd0, 5'(n)});
      end
    end
  endtask

  // 300 idle BX, then l1acc: address wraps; L1_DELAY=3 reads slot 41.
  task automatic test_wrap();
    logic ev0, ev3;
    logic [29:0] ed0, ed3;
    logic [479:0] d, d297;
    logic [29:0] h0, h3, first3;
    logic [15:0] rr;
    int k0, k3;
    rr = 16'($urandom) | 16'h0001;
    h0 = '0; h3 = '0; first3 = '0; k0 = 0; k3 = 0; d297 = '0;
    do_reset();
    for (int c = 0; c < 325; c++) begin
      d = rand_din();
      if (c == 297) d297 = d;
      bx(c == 300, 1'b0, (c == 300) ? rr : 16'($urandom), d, ev0, ed0, ev3, ed3);
      n_checks++;
      if (dout_valid0 !== ev0 || dout0 !== ed0) begin
        n_err++; $display("FAIL wrap_stream0 cyc=%0d got v=%b d=%h exp v=%b d=%h", c, dout_valid0, dout0, ev0, ed0);
      end
      n_checks++;
      if (dout_valid3 !== ev3 || dout3 !== ed3) begin
        n_err++; $display("FAIL wrap_stream3 cyc=%0d got v=%b d=%h exp v=%b d=%h", c, dout_valid3, dout3, ev3, ed3);
      end
      if (dout_valid0 === 1'b1) begin if (k0 == 0) h0 = dout0; k0++; end
      if (dout_valid3 === 1'b1) begin
        if (k3 == 0) h3 = dout3;
        if (k3 == 1) first3 = dout3;
        k3++;
      end
    end
    n_checks++;
    if (h0[23:16] !== 8'd44) begin n_err++; $display("FAIL wrap_t0 got=%0d exp=44", h0[23:16]); end
    n_checks++;
    if (h3[23:16] !== 8'd41) begin n_err++; $display("FAIL wrap_t3 got=%0d exp=41", h3[23:16]); end
    n_checks++;
    if (first3 !== d297[29:0]) begin n_err++; $display("FAIL wrap_lap2 got=%h exp=%h", first3, d297[29:0]); end
  endtask

  // bc0, trigger 5 BX later (T=4), a dropped l1acc inside the packet, then
  // a trigger on the first idle edge after the packet (T=5).
  task automatic test_bc0();
    logic ev0, ev3;
    logic [29:0] ed0, ed3;
    logic [29:0] hdr0[$], hdr3[$];
    logic [15:0] r1;
    logic prev0, prev3;
    int n, c2;
    r1 = 16'($urandom);
    n  = $countones(r1);
    c2 = 8 + n + 3;
    prev0 = 1'b0; prev3 = 1'b0;
    for (int c = 0; c < c2 + 24; c++) begin
      bx((c == 8) || (c == 10) || (c == c2), c == 3, (c == 8) ? r1 : 16'($urandom), rand_din(), ev0, ed0, ev3, ed3);
      n_checks++;
      if (dout_valid0 !== ev0 || dout0 !== ed0) begin
        n_err++; $display("FAIL bc0_stream0 cyc=%0d got v=%b d=%h exp v=%b d=%h", c, dout_valid0, dout0, ev0, ed0);
      end
      n_checks++;
      if (dout_valid3 !== ev3 || dout3 !== ed3) begin
        n_err++; $display("FAIL bc0_stream3 cyc=%0d got v=%b d=%h exp v=%b d=%h", c, dout_valid3, dout3, ev3, ed3);
      end
      if (dout_valid0 === 1'b1 && !prev0) hdr0.push_back(dout0);
      if (dout_valid3 === 1'b1 && !prev3) hdr3.push_back(dout3);
      prev0 = dout_valid0;
      prev3 = dout_valid3;
    end
    n_checks++;
    if (hdr0.size() != 2) begin n_err++; $display("FAIL bc0_packets got=%0d exp=2", hdr0.size()); end
    if (hdr0.size() == 2 && hdr3.size() == 2) begin
      n_checks++;
      if (hdr0[0][23:16] !== 8'd4) begin n_err++; $display("FAIL bc0_t0 got=%0d exp=4", hdr0[0][23:16]); end
      n_checks++;
      if (hdr0[1][23:16] !== 8'd5) begin n_err++; $display("FAIL bc0_resume got=%0d exp=5", hdr0[1][23:16]); end
      n_checks++;
      if (hdr3[1][23:16] !== 8'd2) begin n_err++; $display("FAIL bc0_resume3 got=%0d exp=2", hdr3[1][23:16]); end
    end
  endtask

  // Reset mid-way through a full packet, then trigger after 7 BX.
  task automatic test_reset_mid();
    logic ev0, ev3;
    logic [29:0] ed0, ed3;
    logic [29:0] h0, h3;
    int k0, k3;
    h0 = '0; h3 = '0; k0 = 0; k3 = 0;
    for (int c = 0; c < 9; c++) begin
      bx(c == 2, 1'b0, 16'hFFFF, rand_din(), ev0, ed0, ev3, ed3);
      n_checks++;
      if (dout_valid0 !== ev0 || dout0 !== ed0) begin
        n_err++; $display("FAIL rmid_stream0 cyc=%0d got v=%b d=%h exp v=%b d=%h", c, dout_valid0, dout0, ev0, ed0);
      end
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dout0 !== 30'd0 || dout_valid0 !== 1'b0) begin
      n_err++; $display("FAIL rmid_abort0 got v=%b d=%h exp v=0 d=0", dout_valid0, dout0);
    end
    n_checks++;
    if (dout3 !== 30'd0 || dout_valid3 !== 1'b0) begin
      n_err++; $display("FAIL rmid_abort3 got v=%b d=%h exp v=0 d=0", dout_valid3, dout3);
    end
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bx(c == 7, 1'b0, 16'($urandom), rand_din(), ev0, ed0, ev3, ed3);
      n_checks++;
      if (dout_valid0 !== ev0 || dout0 !== ed0) begin
        n_err++; $display("FAIL rmid_after0 cyc=%0d got v=%b d=%h exp v=%b d=%h", c, dout_valid0, dout0, ev0, ed0);
      end
      n_checks++;
      if (dout_valid3 !== ev3 || dout3 !== ed3) begin
        n_err++; $display("FAIL rmid_after3 cyc=%0d got v=%b d=%h exp v=%b d=%h", c, dout_valid3, dout3, ev3, ed3);
      end
      if (dout_valid0 === 1'b1) begin if (k0 == 0) h0 = dout0; k0++; end
      if (dout_valid3 === 1'b1) begin if (k3 == 0) h3 = dout3; k3++; end
    end
    n_checks++;
    if (h0[23:16] !== 8'd7) begin n_err++; $display("FAIL rmid_t0 got=%0d exp=7", h0[23:16]); end
    n_checks++;
    if (h3[23:16] !== 8'd4) begin n_err++; $display("FAIL rmid_t3 got=%0d exp=4", h3[23:16]); end
  endtask

  initial begin
    test_reset();
    test_trigger(16'h0001);
    test_trigger(16'hFFFF);
    test_trigger(16'h0000);
    test_trigger(16'($urandom));
    test_wrap();
    test_bc0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
